// File: rtl/gcd_driver_pkg.sv
// Shared definitions for the GCD initiator: FSM state encoding and the default operand width
// that must agree with the responder.
package gcd_driver_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/gcd_driver_req_fifo.sv
// Request buffer for operand pairs: DEPTH x DW synchronous FIFO with full/empty flags.
// Data storage is not reset; only pointers and occupancy are.
module gcd_req_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE_C  = (AW + 1)'(1);
   localparam logic [AW-1:0] PONE_C = AW'(1);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;

   // Entry storage write
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW + 1){1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PONE_C;
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PONE_C;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign full  = (count_r == FULL_C);
   assign empty = (count_r == {(AW + 1){1'b0}});

endmodule

// File: rtl/gcd_driver.sv
// GCD initiator: buffers operand pairs, issues them one at a time to a START/DONE responder,
// and returns each result (or a timeout) on an in-order valid/ready stream.
module gcd_driver
   import gcd_driver_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [WIDTH-1:0] REQ_A,
   input  logic [WIDTH-1:0] REQ_B,
   output logic [WIDTH-1:0] GCD_A,
   output logic [WIDTH-1:0] GCD_B,
   output logic             GCD_START,
   input  logic [WIDTH-1:0] GCD_Y,
   input  logic             GCD_DONE,
   input  logic             GCD_ERROR,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [WIDTH-1:0] RSP_Y,
   output logic             RSP_ERR,
   output logic             RSP_TIMEOUT,
   output logic             BUSY
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   state_t             state_r;
   state_t             state_s;
   logic               pop_s;
   logic               push_s;
   logic               full_s;
   logic               empty_s;
   logic               timeout_s;
   logic [2*WIDTH-1:0] head_s;
   logic [CW-1:0]      cnt_r;
   logic [WIDTH-1:0]   gcd_a_r;
   logic [WIDTH-1:0]   gcd_b_r;
   logic [WIDTH-1:0]   rsp_y_r;
   logic               gcd_start_r;
   logic               rsp_valid_r;
   logic               rsp_err_r;
   logic               rsp_timeout_r;

   assign push_s    = REQ_VALID && !full_s;
   assign timeout_s = (cnt_r == TMO_C);

   gcd_req_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push_s),
      .pop   (pop_s),
      .wdata ({REQ_A, REQ_B}),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Next-state and FIFO pop decision; DONE takes priority over timeout
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_s = ST_WAIT;
         ST_WAIT: begin
            if (GCD_DONE || timeout_s) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (RSP_READY) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, operand, wait-counter and result registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r       <= ST_IDLE;
         gcd_a_r       <= {WIDTH{1'b0}};
         gcd_b_r       <= {WIDTH{1'b0}};
         gcd_start_r   <= 1'b0;
         rsp_valid_r   <= 1'b0;
         rsp_y_r       <= {WIDTH{1'b0}};
         rsp_err_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
         cnt_r         <= {CW{1'b0}};
      end else begin
         state_r     <= state_s;
         gcd_start_r <= (state_s == ST_ISSUE);
         rsp_valid_r <= (state_s == ST_RESP);
         if (pop_s) begin
            gcd_a_r <= head_s[2*WIDTH-1:WIDTH];
            gcd_b_r <= head_s[WIDTH-1:0];
         end
         case (state_r)
            ST_ISSUE: cnt_r <= {CW{1'b0}};
            ST_WAIT: begin
               if (GCD_DONE) begin
                  rsp_y_r       <= GCD_Y;
                  rsp_err_r     <= GCD_ERROR;
                  rsp_timeout_r <= 1'b0;
               end else if (timeout_s) begin
                  rsp_y_r       <= {WIDTH{1'b0}};
                  rsp_err_r     <= 1'b0;
                  rsp_timeout_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + ONE_C;
               end
            end
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   assign REQ_READY   = !full_s;
   assign GCD_A       = gcd_a_r;
   assign GCD_B       = gcd_b_r;
   assign GCD_START   = gcd_start_r;
   assign RSP_VALID   = rsp_valid_r;
   assign RSP_Y       = rsp_y_r;
   assign RSP_ERR     = rsp_err_r;
   assign RSP_TIMEOUT = rsp_timeout_r;
   assign BUSY        = (state_r != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_gcd_driver.sv
// Scoreboard bench for gcd_driver: behavioural GCD responder, expected results queued at push
// time, monitor compares every accepted response in order.
module tb_gcd_driver;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int TO = 16;

   typedef struct packed {
      logic [W-1:0] y;
      logic         err;
      logic         to;
   } rsp_t;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         REQ_VALID = 1'b0;
   logic         REQ_READY;
   logic [W-1:0] REQ_A = '0;
   logic [W-1:0] REQ_B = '0;
   logic [W-1:0] GCD_A;
   logic [W-1:0] GCD_B;
   logic         GCD_START;
   logic [W-1:0] GCD_Y = '0;
   logic         GCD_DONE = 1'b0;
   logic         GCD_ERROR = 1'b0;
   logic         RSP_VALID;
   logic         RSP_READY = 1'b1;
   logic [W-1:0] RSP_Y;
   logic         RSP_ERR;
   logic         RSP_TIMEOUT;
   logic         BUSY;

   rsp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   n_rsp = 0;
   int   n_start = 0;
   int   cyc = 0;
   bit   silent = 1'b0;
   int   lat_cfg = 1;
   bit   rand_ready = 1'b0;
   bit   hold_v = 1'b0;
   rsp_t hold_d;

   gcd_driver #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .GCD_A(GCD_A), .GCD_B(GCD_B), .GCD_START(GCD_START),
      .GCD_Y(GCD_Y), .GCD_DONE(GCD_DONE), .GCD_ERROR(GCD_ERROR), .RSP_VALID(RSP_VALID),
      .RSP_READY(RSP_READY), .RSP_Y(RSP_Y), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
      .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc = cyc + 1;

   always @(negedge CLK) if (GCD_START) n_start = n_start + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      int x = int'(a);
      int y = int'(b);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return W'(x);
   endfunction

   // Result the driver must return: timeout when responder is silent, otherwise the responder's Y/ERR
   function automatic rsp_t expect_rsp(input logic [W-1:0] a, input logic [W-1:0] b, input bit sil);
      rsp_t r;
      if (sil) begin
         r.y = '0; r.err = 1'b0; r.to = 1'b1;
      end else begin
         r.y = ref_gcd(a, b); r.err = (a == 0 || b == 0); r.to = 1'b0;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rand_ready) RSP_READY = 1'($urandom_range(0, 1));
   endtask

   task automatic push_req(input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 1'b0;
      REQ_A = a; REQ_B = b; REQ_VALID = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge CLK);
         if (REQ_READY) begin
            ok = 1'b1;
            sb.push_back(expect_rsp(a, b, silent));
         end
         tick();
      end
      REQ_VALID = 1'b0;
      if (!ok) begin
         total = total + 1; bad = bad + 1;
         $display("FAIL push_timeout: REQ_READY never seen for a=%0d b=%0d", a, b);
      end
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (sb.size() == 0 && !BUSY) break;
      end
      chk(nm, 32'(sb.size()), 32'd0);
      chk({nm, "_idle"}, 32'(BUSY), 32'd0);
   endtask

   task automatic wait_valid(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge CLK);
         seen = RSP_VALID;
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   // Behavioural responder: latches operands on START, answers after a latency or stays silent
   initial begin : responder
      logic [W-1:0] ra, rb;
      int lat;
      bit sil, aborted;
      forever begin
         @(posedge CLK);
         #1;
         GCD_DONE = 1'b0;
         if (!RST && GCD_START) begin
            ra = GCD_A; rb = GCD_B; sil = silent; aborted = 1'b0;
            lat = sil ? TO + 4 : (lat_cfg == 0 ? int'($urandom_range(1, 6)) : lat_cfg);
            for (int i = 0; i < lat; i++) begin
               @(posedge CLK);
               #1;
               if (RST) aborted = 1'b1;
               else if (!sil && !aborted) begin
                  chk("gcd_a_stable", 32'(GCD_A), 32'(ra));
                  chk("gcd_b_stable", 32'(GCD_B), 32'(rb));
               end
            end
            if (!aborted) begin
               GCD_Y     = sil ? 8'hAA : ref_gcd(ra, rb);
               GCD_ERROR = sil ? 1'b1 : (ra == 0 || rb == 0);
               GCD_DONE  = 1'b1;
            end
         end
      end
   end

   // Monitor: in-order compare of accepted responses, and hold checks while stalled
   always @(negedge CLK) begin : monitor
      rsp_t e;
      if (RST) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("rsp_hold_valid", 32'(RSP_VALID), 32'd1);
            chk("rsp_hold_data", 32'({RSP_Y, RSP_ERR, RSP_TIMEOUT}), 32'(hold_d));
         end
         if (RSP_VALID) chk("no_start_in_resp", 32'(GCD_START), 32'd0);
         if (RSP_VALID && RSP_READY) begin
            n_rsp = n_rsp + 1;
            if (sb.size() == 0) begin
               total = total + 1; bad = bad + 1;
               $display("FAIL unexpected_rsp: got y=%0d err=%0b to=%0b expected none",
                        RSP_Y, RSP_ERR, RSP_TIMEOUT);
            end else begin
               e = sb.pop_front();
               chk("rsp_y", 32'(RSP_Y), 32'(e.y));
               chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
               chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e.to));
            end
         end
         hold_v = RSP_VALID && !RSP_READY;
         hold_d = {RSP_Y, RSP_ERR, RSP_TIMEOUT};
      end
   end

   task automatic check_reset_values(input string nm);
      chk({nm, "_gcd_a"}, 32'(GCD_A), 32'd0);
      chk({nm, "_gcd_b"}, 32'(GCD_B), 32'd0);
      chk({nm, "_start"}, 32'(GCD_START), 32'd0);
      chk({nm, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
      chk({nm, "_rsp_y"}, 32'(RSP_Y), 32'd0);
      chk({nm, "_rsp_err"}, 32'(RSP_ERR), 32'd0);
      chk({nm, "_rsp_to"}, 32'(RSP_TIMEOUT), 32'd0);
      chk({nm, "_busy"}, 32'(BUSY), 32'd0);
      chk({nm, "_req_ready"}, 32'(REQ_READY), 32'd1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int s0, r0, st;
      bit seen;
      logic [W-1:0] a, b;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_reset_values("reset");
      tick();
      RST = 1'b0;
      repeat (2) tick();

      // 1: basic 48/18, single START with the right operands
      lat_cfg = 2; s0 = n_start;
      push_req(8'd48, 8'd18);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         seen = GCD_START;
      end
      chk("t1_start_seen", 32'(seen), 32'd1);
      chk("t1_gcd_a", 32'(GCD_A), 32'd48);
      chk("t1_gcd_b", 32'(GCD_B), 32'd18);
      tick();
      wait_drain("t1_drain");
      chk("t1_one_start", 32'(n_start - s0), 32'd1);

      // 2: zero operand -> responder error passed through
      push_req(8'd0, 8'd5);
      wait_drain("t2_drain");

      // 3: stalled output, 6 back-to-back pushes: 1 in flight, 4 buffered, 6th held off
      RSP_READY = 1'b0; lat_cfg = 1; r0 = n_rsp;
      push_req(8'd12, 8'd9);
      push_req(8'd100, 8'd40);
      push_req(8'd7, 8'd0);
      push_req(8'd81, 8'd27);
      push_req(8'd64, 8'd48);
      @(negedge CLK);
      chk("t3_full_ready", 32'(REQ_READY), 32'd0);
      chk("t3_busy", 32'(BUSY), 32'd1);
      tick();
      fork
         push_req(8'd221, 8'd17);
         begin
            repeat (5) begin
               @(posedge CLK);
               #1;
            end
            chk("t3_still_full", 32'(REQ_READY), 32'd0);
            RSP_READY = 1'b1;
         end
      join
      wait_drain("t3_drain");
      chk("t3_rsp_count", 32'(n_rsp - r0), 32'd6);

      // 4: silent responder; START cycle plus TIMEOUT+1 WAIT cycles before RSP_VALID appears
      silent = 1'b1; st = -1;
      push_req(8'd7, 8'd3);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge CLK);
         if (GCD_START && st < 0) st = cyc;
         seen = RSP_VALID;
      end
      chk("t4_rsp_seen", 32'(seen), 32'd1);
      chk("t4_timeout_latency", 32'(cyc - st), 32'(TO + 2));
      tick();
      wait_drain("t4_drain");
      repeat (12) tick();
      silent = 1'b0; r0 = n_rsp;
      push_req(8'd100, 8'd75);
      wait_drain("t4_next_drain");
      chk("t4_next_count", 32'(n_rsp - r0), 32'd1);

      // 5: output stalled 10 cycles with a second request waiting: no new START
      RSP_READY = 1'b0; lat_cfg = 3;
      push_req(8'd35, 8'd14);
      wait_valid("t5_valid");
      tick();
      push_req(8'd9, 8'd6);
      s0 = n_start;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("t5_valid_held", 32'(RSP_VALID), 32'd1);
      end
      chk("t5_no_start", 32'(n_start - s0), 32'd0);
      tick();
      RSP_READY = 1'b1;
      wait_drain("t5_drain");

      // Randomized traffic with random latency and random downstream backpressure
      rand_ready = 1'b1; lat_cfg = 0; r0 = n_rsp;
      for (int k = 0; k < 25; k++) begin
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) a = '0;
         push_req(a, b);
         repeat ($urandom_range(0, 3)) tick();
      end
      rand_ready = 1'b0; RSP_READY = 1'b1;
      wait_drain("rand_drain");
      chk("rand_count", 32'(n_rsp - r0), 32'd25);

      // 6: reset while waiting with 3 requests queued drops everything
      silent = 1'b1;
      push_req(8'd12, 8'd8);
      push_req(8'd5, 8'd5);
      push_req(8'd9, 8'd3);
      push_req(8'd4, 8'd2);
      @(negedge CLK);
      chk("t6_busy", 32'(BUSY), 32'd1);
      tick();
      RST = 1'b1;
      sb.delete();
      r0 = n_rsp;
      @(negedge CLK);
      check_reset_values("t6_reset");
      tick();
      RST = 1'b0;
      silent = 1'b0;
      repeat (40) tick();
      chk("t6_no_rsp", 32'(n_rsp - r0), 32'd0);
      chk("t6_idle", 32'(BUSY), 32'd0);
      chk("t6_ready", 32'(REQ_READY), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
